// File: rtl/nasti_mem_bridge_if.sv
// Shim-side (in_*) and PS-side (out_*) AXI channels of the NastiShim memory bridge.
// The bridge uses modport slave; the shim/PS environment uses modport master.
interface nasti_mem_bridge_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 6
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              in_ar_valid, in_ar_ready;
  logic [ADDR_W-1:0] in_ar_addr;
  logic [ID_W-1:0]   in_ar_id;
  logic [7:0]        in_ar_len;
  logic [2:0]        in_ar_size;

  logic              in_aw_valid, in_aw_ready;
  logic [ADDR_W-1:0] in_aw_addr;
  logic [ID_W-1:0]   in_aw_id;
  logic [7:0]        in_aw_len;
  logic [2:0]        in_aw_size;

  logic              in_w_valid, in_w_ready, in_w_last;
  logic [DATA_W-1:0] in_w_data;

  logic              in_r_valid, in_r_ready, in_r_last;
  logic [DATA_W-1:0] in_r_data;
  logic [ID_W-1:0]   in_r_id;
  logic [1:0]        in_r_resp;

  logic              in_b_valid, in_b_ready;
  logic [ID_W-1:0]   in_b_id;
  logic [1:0]        in_b_resp;

  logic              out_ar_valid, out_ar_ready, out_ar_lock;
  logic [ADDR_W-1:0] out_ar_addr;
  logic [ID_W-1:0]   out_ar_id;
  logic [7:0]        out_ar_len;
  logic [2:0]        out_ar_size, out_ar_prot;
  logic [1:0]        out_ar_burst;
  logic [3:0]        out_ar_cache, out_ar_qos, out_ar_region;

  logic              out_aw_valid, out_aw_ready, out_aw_lock;
  logic [ADDR_W-1:0] out_aw_addr;
  logic [ID_W-1:0]   out_aw_id;
  logic [7:0]        out_aw_len;
  logic [2:0]        out_aw_size, out_aw_prot;
  logic [1:0]        out_aw_burst;
  logic [3:0]        out_aw_cache, out_aw_qos, out_aw_region;

  logic              out_w_valid, out_w_ready, out_w_last;
  logic [DATA_W-1:0] out_w_data;
  logic [STRB_W-1:0] out_w_strb;

  logic              out_r_valid, out_r_ready, out_r_last;
  logic [DATA_W-1:0] out_r_data;
  logic [ID_W-1:0]   out_r_id;
  logic [1:0]        out_r_resp;

  logic              out_b_valid, out_b_ready;
  logic [ID_W-1:0]   out_b_id;
  logic [1:0]        out_b_resp;

  modport slave (
    input  in_ar_valid, in_ar_addr, in_ar_id, in_ar_len, in_ar_size,
    output in_ar_ready,
    input  in_aw_valid, in_aw_addr, in_aw_id, in_aw_len, in_aw_size,
    output in_aw_ready,
    input  in_w_valid, in_w_data, in_w_last,
    output in_w_ready,
    output in_r_valid, in_r_data, in_r_id, in_r_resp, in_r_last,
    input  in_r_ready,
    output in_b_valid, in_b_id, in_b_resp,
    input  in_b_ready,
    output out_ar_valid, out_ar_addr, out_ar_id, out_ar_len, out_ar_size, out_ar_burst,
           out_ar_cache, out_ar_prot, out_ar_qos, out_ar_region, out_ar_lock,
    input  out_ar_ready,
    output out_aw_valid, out_aw_addr, out_aw_id, out_aw_len, out_aw_size, out_aw_burst,
           out_aw_cache, out_aw_prot, out_aw_qos, out_aw_region, out_aw_lock,
    input  out_aw_ready,
    output out_w_valid, out_w_data, out_w_strb, out_w_last,
    input  out_w_ready,
    input  out_r_valid, out_r_data, out_r_id, out_r_resp, out_r_last,
    output out_r_ready,
    input  out_b_valid, out_b_id, out_b_resp,
    output out_b_ready
  );

  modport master (
    output in_ar_valid, in_ar_addr, in_ar_id, in_ar_len, in_ar_size,
    input  in_ar_ready,
    output in_aw_valid, in_aw_addr, in_aw_id, in_aw_len, in_aw_size,
    input  in_aw_ready,
    output in_w_valid, in_w_data, in_w_last,
    input  in_w_ready,
    input  in_r_valid, in_r_data, in_r_id, in_r_resp, in_r_last,
    output in_r_ready,
    input  in_b_valid, in_b_id, in_b_resp,
    output in_b_ready,
    input  out_ar_valid, out_ar_addr, out_ar_id, out_ar_len, out_ar_size, out_ar_burst,
           out_ar_cache, out_ar_prot, out_ar_qos, out_ar_region, out_ar_lock,
    output out_ar_ready,
    input  out_aw_valid, out_aw_addr, out_aw_id, out_aw_len, out_aw_size, out_aw_burst,
           out_aw_cache, out_aw_prot, out_aw_qos, out_aw_region, out_aw_lock,
    output out_aw_ready,
    input  out_w_valid, out_w_data, out_w_strb, out_w_last,
    output out_w_ready,
    output out_r_valid, out_r_data, out_r_id, out_r_resp, out_r_last,
    input  out_r_ready,
    output out_b_valid, out_b_id, out_b_resp,
    input  out_b_ready
  );
endinterface

// File: rtl/nasti_mem_bridge.sv
// NastiShim memory master -> PS HP/ACP AXI bridge: address remap, AR/AW slices, outstanding caps.
// Define NASTI_MEM_BRIDGE_BOUNDS_CHECK_EN to terminate out-of-window accesses locally with DECERR.
module nasti_mem_bridge #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 64,
  parameter int unsigned       ID_W     = 6,
  parameter int unsigned       WIN_BITS = 28,
  parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(32'h1000_0000),
  parameter int unsigned       MAX_RD   = 4,
  parameter int unsigned       MAX_WR   = 4
) (
  input  logic               clk,
  input  logic               reset,
  nasti_mem_bridge_if.slave  io
);
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned RD_CW  = $clog2(MAX_RD + 1);
  localparam int unsigned WR_CW  = $clog2(MAX_WR + 1);
  localparam int unsigned HI_W   = ADDR_W - WIN_BITS;
  localparam logic [HI_W-1:0] BASE_HI = MEM_BASE[ADDR_W-1:WIN_BITS];

  logic              ar_full, aw_full;
  logic [ADDR_W-1:0] ar_addr_q, aw_addr_q;
  logic [ID_W-1:0]   ar_id_q, aw_id_q;
  logic [7:0]        ar_len_q, aw_len_q;
  logic [2:0]        ar_size_q, aw_size_q;
  logic [RD_CW-1:0]  rd_cnt;
  logic [WR_CW-1:0]  wr_cnt;

  logic ar_oob, aw_oob, ar_err_ok, aw_err_ok;
  logic ar_credit, aw_credit, ar_fire, aw_fire, ar_fwd, aw_fwd;
  logic rd_done, wr_done;

  assign ar_credit = rd_cnt < RD_CW'(MAX_RD);
  assign aw_credit = wr_cnt < WR_CW'(MAX_WR);

  assign io.in_ar_ready = !reset && (ar_oob ? ar_err_ok
                                            : ((!ar_full || io.out_ar_ready) && ar_credit));
  assign io.in_aw_ready = !reset && (aw_oob ? aw_err_ok
                                            : ((!aw_full || io.out_aw_ready) && aw_credit));

  assign ar_fire = io.in_ar_valid && io.in_ar_ready;
  assign aw_fire = io.in_aw_valid && io.in_aw_ready;
  assign ar_fwd  = ar_fire && !ar_oob;
  assign aw_fwd  = aw_fire && !aw_oob;
  assign rd_done = io.out_r_valid && io.out_r_ready && io.out_r_last;
  assign wr_done = io.out_b_valid && io.out_b_ready;

  // Slice occupancy: load wins over drain so a full slice can refill in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_full <= 1'b0;
      aw_full <= 1'b0;
    end else begin
      if (ar_fwd)               ar_full <= 1'b1;
      else if (io.out_ar_ready) ar_full <= 1'b0;
      if (aw_fwd)               aw_full <= 1'b1;
      else if (io.out_aw_ready) aw_full <= 1'b0;
    end
  end

  // Remap happens at capture so the PS side only ever sees in-window addresses.
  always_ff @(posedge clk) begin
    if (ar_fwd) begin
      ar_addr_q <= {BASE_HI, io.in_ar_addr[WIN_BITS-1:0]};
      ar_id_q   <= io.in_ar_id;
      ar_len_q  <= io.in_ar_len;
      ar_size_q <= io.in_ar_size;
    end
    if (aw_fwd) begin
      aw_addr_q <= {BASE_HI, io.in_aw_addr[WIN_BITS-1:0]};
      aw_id_q   <= io.in_aw_id;
      aw_len_q  <= io.in_aw_len;
      aw_size_q <= io.in_aw_size;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      case ({ar_fwd, rd_done})
        2'b10:   rd_cnt <= rd_cnt + RD_CW'(1);
        2'b01:   if (rd_cnt != '0) rd_cnt <= rd_cnt - RD_CW'(1);
        default: rd_cnt <= rd_cnt;
      endcase
      case ({aw_fwd, wr_done})
        2'b10:   wr_cnt <= wr_cnt + WR_CW'(1);
        2'b01:   if (wr_cnt != '0) wr_cnt <= wr_cnt - WR_CW'(1);
        default: wr_cnt <= wr_cnt;
      endcase
    end
  end

  assign io.out_ar_valid  = ar_full;
  assign io.out_ar_addr   = ar_addr_q;
  assign io.out_ar_id     = ar_id_q;
  assign io.out_ar_len    = ar_len_q;
  assign io.out_ar_size   = ar_size_q;
  assign io.out_ar_burst  = 2'b01;
  assign io.out_ar_cache  = 4'b0011;
  assign io.out_ar_prot   = 3'b000;
  assign io.out_ar_qos    = 4'b0000;
  assign io.out_ar_region = 4'b0000;
  assign io.out_ar_lock   = 1'b0;

  assign io.out_aw_valid  = aw_full;
  assign io.out_aw_addr   = aw_addr_q;
  assign io.out_aw_id     = aw_id_q;
  assign io.out_aw_len    = aw_len_q;
  assign io.out_aw_size   = aw_size_q;
  assign io.out_aw_burst  = 2'b01;
  assign io.out_aw_cache  = 4'b0011;
  assign io.out_aw_prot   = 3'b000;
  assign io.out_aw_qos    = 4'b0000;
  assign io.out_aw_region = 4'b0000;
  assign io.out_aw_lock   = 1'b0;

  assign io.out_w_data = io.in_w_data;
  assign io.out_w_last = io.in_w_last;
  assign io.out_w_strb = {STRB_W{1'b1}};

`ifdef NASTI_MEM_BRIDGE_BOUNDS_CHECK_EN
  localparam logic [1:0] RD_IDLE  = 2'd0;
  localparam logic [1:0] RD_ERR   = 2'd1;
  localparam logic [1:0] WR_IDLE  = 2'd0;
  localparam logic [1:0] WR_DRAIN = 2'd1;
  localparam logic [1:0] WR_RESP  = 2'd2;

  logic [1:0]      rd_state, rd_state_nxt, wr_state, wr_state_nxt;
  logic [7:0]      rd_beats;
  logic [ID_W-1:0] rd_err_id, wr_err_id;

  // Error bursts start only with nothing in flight, so DECERR beats never interleave with PS data.
  assign ar_oob    = |io.in_ar_addr[ADDR_W-1:WIN_BITS];
  assign aw_oob    = |io.in_aw_addr[ADDR_W-1:WIN_BITS];
  assign ar_err_ok = (rd_state == RD_IDLE) && (rd_cnt == '0) && !ar_full;
  assign aw_err_ok = (wr_state == WR_IDLE) && (wr_cnt == '0) && !aw_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
    end else begin
      rd_state <= rd_state_nxt;
      wr_state <= wr_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_fire && ar_oob) begin
      rd_beats  <= io.in_ar_len;
      rd_err_id <= io.in_ar_id;
    end else if (rd_state == RD_ERR && io.in_r_ready && rd_beats != 8'd0) begin
      rd_beats <= rd_beats - 8'd1;
    end
    if (aw_fire && aw_oob) wr_err_id <= io.in_aw_id;
  end

  always_comb begin
    rd_state_nxt   = rd_state;
    io.in_r_valid  = io.out_r_valid;
    io.in_r_data   = io.out_r_data;
    io.in_r_id     = io.out_r_id;
    io.in_r_resp   = io.out_r_resp;
    io.in_r_last   = io.out_r_last;
    io.out_r_ready = io.in_r_ready;
    case (rd_state)
      RD_IDLE: if (ar_fire && ar_oob) rd_state_nxt = RD_ERR;
      RD_ERR: begin
        io.in_r_valid  = 1'b1;
        io.in_r_data   = '0;
        io.in_r_id     = rd_err_id;
        io.in_r_resp   = 2'b11;
        io.in_r_last   = (rd_beats == 8'd0);
        io.out_r_ready = 1'b0;
        if (io.in_r_ready && rd_beats == 8'd0) rd_state_nxt = RD_IDLE;
      end
      default: rd_state_nxt = RD_IDLE;
    endcase
  end

  always_comb begin
    wr_state_nxt   = wr_state;
    io.in_w_ready  = !reset && io.out_w_ready;
    io.out_w_valid = io.in_w_valid;
    io.in_b_valid  = io.out_b_valid;
    io.in_b_id     = io.out_b_id;
    io.in_b_resp   = io.out_b_resp;
    io.out_b_ready = io.in_b_ready;
    case (wr_state)
      WR_IDLE: if (aw_fire && aw_oob) wr_state_nxt = WR_DRAIN;
      WR_DRAIN: begin
        io.in_w_ready  = !reset;
        io.out_w_valid = 1'b0;
        if (io.in_w_valid && io.in_w_last) wr_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        io.in_b_valid  = 1'b1;
        io.in_b_id     = wr_err_id;
        io.in_b_resp   = 2'b11;
        io.out_b_ready = 1'b0;
        if (io.in_b_ready) wr_state_nxt = WR_IDLE;
      end
      default: wr_state_nxt = WR_IDLE;
    endcase
  end
`else
  assign ar_oob    = 1'b0;
  assign aw_oob    = 1'b0;
  assign ar_err_ok = 1'b0;
  assign aw_err_ok = 1'b0;

  assign io.in_r_valid  = io.out_r_valid;
  assign io.in_r_data   = io.out_r_data;
  assign io.in_r_id     = io.out_r_id;
  assign io.in_r_resp   = io.out_r_resp;
  assign io.in_r_last   = io.out_r_last;
  assign io.out_r_ready = io.in_r_ready;

  assign io.in_w_ready  = !reset && io.out_w_ready;
  assign io.out_w_valid = io.in_w_valid;

  assign io.in_b_valid  = io.out_b_valid;
  assign io.in_b_id     = io.out_b_id;
  assign io.in_b_resp   = io.out_b_resp;
  assign io.out_b_ready = io.in_b_ready;
`endif
endmodule

// File: tb/tb_nasti_mem_bridge.sv
// Directed bench for nasti_mem_bridge: remap, credits, slices, write path, bounds check, reset.
module tb_nasti_mem_bridge;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  nasti_mem_bridge_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) io ();

  nasti_mem_bridge dut (.clk(clk), .reset(reset), .io(io));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    io.in_ar_valid = 0; io.in_ar_addr = '0; io.in_ar_id = '0; io.in_ar_len = '0; io.in_ar_size = 3'd3;
    io.in_aw_valid = 0; io.in_aw_addr = '0; io.in_aw_id = '0; io.in_aw_len = '0; io.in_aw_size = 3'd3;
    io.in_w_valid = 0; io.in_w_data = '0; io.in_w_last = 0;
    io.in_r_ready = 0; io.in_b_ready = 0;
    io.out_ar_ready = 0; io.out_aw_ready = 0; io.out_w_ready = 0;
    io.out_r_valid = 0; io.out_r_data = '0; io.out_r_id = '0; io.out_r_resp = '0; io.out_r_last = 0;
    io.out_b_valid = 0; io.out_b_id = '0; io.out_b_resp = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    io.in_ar_valid = 1'b1;
    step(); step();
    chk("reset_in_ar_ready", 64'(io.in_ar_ready), 64'd0);
    chk("reset_out_ar_valid", 64'(io.out_ar_valid), 64'd0);
    chk("reset_out_aw_valid", 64'(io.out_aw_valid), 64'd0);
    chk("reset_rd_cnt", 64'(dut.rd_cnt), 64'd0);
    chk("reset_wr_cnt", 64'(dut.wr_cnt), 64'd0);
    io.in_ar_valid = 1'b0;
    reset = 1'b0;
    step();
  endtask

  task automatic test_read_remap();
    io.in_ar_valid = 1; io.in_ar_addr = 32'h0123_4560; io.in_ar_len = 8'd3; io.in_ar_id = 6'd2;
    #1 chk("rd_ar_ready", 64'(io.in_ar_ready), 64'd1);
    step();
    io.in_ar_valid = 0;
    #1;
    chk("rd_out_ar_valid", 64'(io.out_ar_valid), 64'd1);
    chk("rd_out_ar_addr", 64'(io.out_ar_addr), 64'h1123_4560);
    chk("rd_out_ar_burst", 64'(io.out_ar_burst), 64'h1);
    chk("rd_out_ar_cache", 64'(io.out_ar_cache), 64'h3);
    chk("rd_out_ar_id_len", 64'({io.out_ar_id, io.out_ar_len}), 64'({6'd2, 8'd3}));
    step();
    chk("rd_ar_stall_hold", 64'(io.out_ar_addr), 64'h1123_4560);
    io.out_ar_ready = 1;
    step();
    io.out_ar_ready = 0;
    #1 chk("rd_ar_drained", 64'(io.out_ar_valid), 64'd0);
    io.in_r_ready = 1;
    for (int i = 0; i < 4; i++) begin
      io.out_r_valid = 1; io.out_r_data = 64'hA0 + 64'(i); io.out_r_id = 6'd2; io.out_r_last = (i == 3);
      #1 chk("rd_r_beat", 64'({io.in_r_valid, io.in_r_last, io.out_r_ready, io.in_r_data[15:0]}),
             64'({1'b1, (i == 3), 1'b1, 16'hA0 + 16'(i)}));
      step();
    end
    io.out_r_valid = 0; io.out_r_last = 0; io.in_r_ready = 0;
    #1 chk("rd_cnt_end", 64'(dut.rd_cnt), 64'd0);
  endtask

  task automatic test_read_credit();
    io.out_ar_ready = 1;
    io.in_ar_valid = 1; io.in_ar_addr = 32'h0000_0100; io.in_ar_len = 8'd0; io.in_ar_id = 6'd1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("cr_accept", 64'(io.in_ar_ready), 64'd1);
      step();
    end
    chk("cr_cnt_full", 64'(dut.rd_cnt), 64'd4);
    for (int i = 0; i < 3; i++) begin
      chk("cr_blocked", 64'(io.in_ar_ready), 64'd0);
      step();
    end
    io.in_r_ready = 1; io.out_r_valid = 1; io.out_r_last = 1; io.out_r_id = 6'd1;
    #1 chk("cr_blocked_on_last", 64'(io.in_ar_ready), 64'd0);
    step();
    io.out_r_valid = 0;
    #1 chk("cr_reopen", 64'(io.in_ar_ready), 64'd1);
    step();
    io.in_ar_valid = 0;
    #1 chk("cr_cnt_refill", 64'(dut.rd_cnt), 64'd4);
    io.out_r_valid = 1;
    for (int i = 0; i < 4; i++) step();
    io.out_r_valid = 0; io.out_r_last = 0; io.in_r_ready = 0; io.out_ar_ready = 0;
    #1 chk("cr_cnt_drained", 64'(dut.rd_cnt), 64'd0);
  endtask

  task automatic test_simultaneous();
    io.out_ar_ready = 1;
    io.in_ar_valid = 1; io.in_ar_addr = 32'h0000_0200; io.in_ar_id = 6'd3;
    step(); step();
    chk("sim_cnt_two", 64'(dut.rd_cnt), 64'd2);
    io.in_r_ready = 1; io.out_r_valid = 1; io.out_r_last = 1; io.out_r_id = 6'd3;
    #1 chk("sim_ar_ready", 64'(io.in_ar_ready), 64'd1);
    step();
    io.in_ar_valid = 0; io.out_r_valid = 0;
    #1 chk("sim_cnt_hold", 64'(dut.rd_cnt), 64'd2);
    io.out_r_valid = 1;
    step(); step();
    io.out_r_valid = 0; io.out_r_last = 0; io.in_r_ready = 0; io.out_ar_ready = 0;
    step();
    chk("sim_cnt_zero", 64'(dut.rd_cnt), 64'd0);
  endtask

  task automatic test_write();
    io.in_aw_valid = 1; io.in_aw_addr = 32'h0000_0040; io.in_aw_len = 8'd1; io.in_aw_id = 6'd7;
    #1 chk("wr_aw_ready", 64'(io.in_aw_ready), 64'd1);
    step();
    io.in_aw_valid = 0;
    #1 chk("wr_out_aw", 64'({io.out_aw_valid, io.out_aw_addr}), 64'({1'b1, 32'h1000_0040}));
    chk("wr_cnt_one", 64'(dut.wr_cnt), 64'd1);
    io.out_aw_ready = 1;
    step();
    io.out_aw_ready = 0;
    io.out_w_ready = 1;
    for (int i = 0; i < 2; i++) begin
      io.in_w_valid = 1; io.in_w_data = 64'h1111_0000 + 64'(i); io.in_w_last = (i == 1);
      #1 chk("wr_w_beat", 64'({io.out_w_valid, io.in_w_ready, io.out_w_last, io.out_w_strb, io.out_w_data[31:0]}),
             64'({1'b1, 1'b1, (i == 1), 8'hff, 32'h1111_0000 + 32'(i)}));
      step();
    end
    io.in_w_valid = 0; io.in_w_last = 0; io.out_w_ready = 0;
    io.out_b_valid = 1; io.out_b_id = 6'd7; io.out_b_resp = 2'b10; io.in_b_ready = 1;
    #1 chk("wr_b_pass", 64'({io.in_b_valid, io.in_b_id, io.in_b_resp, io.out_b_ready}),
           64'({1'b1, 6'd7, 2'b10, 1'b1}));
    step();
    io.out_b_valid = 0; io.in_b_ready = 0;
    #1 chk("wr_cnt_zero", 64'(dut.wr_cnt), 64'd0);
  endtask

  task automatic test_bounds();
    io.in_ar_valid = 1; io.in_ar_addr = 32'h2000_0000; io.in_ar_len = 8'd2; io.in_ar_id = 6'd5;
    #1 chk("oob_ar_ready", 64'(io.in_ar_ready), 64'd1);
    step();
    io.in_ar_valid = 0;
`ifdef NASTI_MEM_BRIDGE_BOUNDS_CHECK_EN
    #1 chk("oob_no_out_ar", 64'(io.out_ar_valid), 64'd0);
    io.in_r_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("oob_r_beat", 64'({io.in_r_valid, io.in_r_resp, io.in_r_id, io.in_r_last, io.out_r_ready, io.in_r_data}),
             64'({1'b1, 2'b11, 6'd5, (i == 2), 1'b0}) << 64 | 64'd0);
      chk("oob_r_fields", 64'({io.in_r_valid, io.in_r_resp, io.in_r_id, io.in_r_last, io.out_r_ready}),
          64'({1'b1, 2'b11, 6'd5, (i == 2), 1'b0}));
      step();
    end
    io.in_r_ready = 0;
    #1 chk("oob_r_done", 64'({io.in_r_valid, dut.rd_cnt}), 64'd0);
    io.in_aw_valid = 1; io.in_aw_addr = 32'hF000_0000; io.in_aw_len = 8'd1; io.in_aw_id = 6'd9;
    #1 chk("oob_aw_ready", 64'(io.in_aw_ready), 64'd1);
    step();
    io.in_aw_valid = 0;
    for (int i = 0; i < 2; i++) begin
      io.in_w_valid = 1; io.in_w_last = (i == 1); io.in_w_data = 64'(i);
      #1 chk("oob_w_absorb", 64'({io.in_w_ready, io.out_w_valid, io.out_aw_valid}), 64'({1'b1, 1'b0, 1'b0}));
      step();
    end
    io.in_w_valid = 0; io.in_w_last = 0;
    #1 chk("oob_b_held", 64'({io.in_b_valid, io.in_b_resp, io.in_b_id}), 64'({1'b1, 2'b11, 6'd9}));
    step();
    chk("oob_b_still", 64'(io.in_b_valid), 64'd1);
    io.in_b_ready = 1;
    step();
    io.in_b_ready = 0;
    #1 chk("oob_b_done", 64'({io.in_b_valid, dut.wr_cnt}), 64'd0);
`else
    #1 chk("oob_remap", 64'({io.out_ar_valid, io.out_ar_addr}), 64'({1'b1, 32'h1000_0000}));
    io.out_ar_ready = 1;
    step();
    io.out_ar_ready = 0;
    io.in_r_ready = 1; io.out_r_valid = 1; io.out_r_last = 1; io.out_r_id = 6'd5;
    #1 chk("oob_r_pass", 64'({io.in_r_valid, io.in_r_id}), 64'({1'b1, 6'd5}));
    step();
    io.out_r_valid = 0; io.out_r_last = 0; io.in_r_ready = 0;
    #1 chk("oob_cnt_zero", 64'(dut.rd_cnt), 64'd0);
`endif
  endtask

  task automatic test_reset_mid();
    io.in_ar_valid = 1; io.in_ar_addr = 32'h0000_1000; io.in_ar_id = 6'd4; io.in_ar_len = 8'd0;
    step();
    io.in_ar_valid = 0;
    #1 chk("rm_slice_full", 64'({io.out_ar_valid, dut.rd_cnt}), 64'({1'b1, 3'd1}));
    reset = 1;
    step();
    reset = 0;
    #1 chk("rm_cleared", 64'({io.out_ar_valid, dut.rd_cnt, dut.wr_cnt}), 64'd0);
    io.in_ar_valid = 1;
    #1 chk("rm_ready_again", 64'(io.in_ar_ready), 64'd1);
    step();
    io.in_ar_valid = 0;
    #1 chk("rm_new_ar", 64'({io.out_ar_valid, io.out_ar_addr}), 64'({1'b1, 32'h1000_1000}));
  endtask

  initial begin
    test_reset();
    test_read_remap();
    test_read_credit();
    test_simultaneous();
    test_write();
    test_bounds();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
